// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the parity-filtered FIFO.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_EVEN_ODD   = 0;
    localparam int DEF_PARITY_BIT = 0;

    // Width needed to index FIFO_DEPTH entries; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/fifo_top_sync_fifo.sv
// Single-clock FIFO storage with wrap flag; the head word is exposed combinationally.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid_i,
    output logic                  push_grant_o,
    input  logic [DATA_WIDTH:0]   push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_grant_i,
    output logic [DATA_WIDTH:0]   pop_data_o
);
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [PTR_W-1:0] ptr_read_q, ptr_read_d;
    logic [PTR_W-1:0] ptr_write_q, ptr_write_d;
    logic             flag_q, flag_d;
    logic             empty, full, push_en, pop_en;

    assign empty        = (ptr_read_q == ptr_write_q) && !flag_q;
    assign full         = (ptr_read_q == ptr_write_q) && flag_q;
    assign push_grant_o = !full;
    assign pop_valid_o  = !empty;
    assign push_en      = push_valid_i && !full;
    assign pop_en       = pop_grant_i && !empty;

    if (1) begin : my_ram
        logic [DATA_WIDTH:0] memory [FIFO_DEPTH];
        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (push_en) begin
                memory[ptr_write_q] <= push_data_i;
            end
        end
    end

    assign pop_data_o = my_ram.memory[ptr_read_q];

    // Both pointers can never wrap in the same cycle: that needs equal pointers,
    // which means empty (no pop) or full (no push).
    always_comb begin
        ptr_read_d  = ptr_read_q;
        ptr_write_d = ptr_write_q;
        flag_d      = flag_q;
        if (push_en) begin
            if (ptr_write_q == PTR_LAST) begin
                ptr_write_d = '0;
                flag_d      = 1'b1;
            end else begin
                ptr_write_d = ptr_write_q + 1'b1;
            end
        end
        if (pop_en) begin
            if (ptr_read_q == PTR_LAST) begin
                ptr_read_d = '0;
                flag_d     = 1'b0;
            end else begin
                ptr_read_d = ptr_read_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_read_q  <= '0;
            ptr_write_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            ptr_read_q  <= ptr_read_d;
            ptr_write_q <= ptr_write_d;
            flag_q      <= flag_d;
        end
    end
endmodule

// File: rtl/fifo_top.sv
// Elastic FIFO with an output parity filter: corrupt head words are flushed, never offered.
module fifo_top
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int EVEN_ODD   = DEF_EVEN_ODD,
    parameter int PARITY_BIT = DEF_PARITY_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WIDTH:0] data_i,
    input  logic                valid_i,
    output logic                grant_o,
    input  logic                grant_i,
    output logic [DATA_WIDTH:0] data_o,
    output logic                valid_o
);
    logic                pop_valid;
    logic                pop_grant;
    logic                head_ok;
    logic [DATA_WIDTH:0] head_word;
    logic [DATA_WIDTH:0] data_q, data_d;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) fifo_i (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (valid_i),
        .push_grant_o (grant_o),
        .push_data_i  (data_i),
        .pop_valid_o  (pop_valid),
        .pop_grant_i  (pop_grant),
        .pop_data_o   (head_word)
    );

    assign head_ok = head_word[PARITY_BIT] == 1'(EVEN_ODD);
    assign valid_o = pop_valid && head_ok;
    // A corrupt head is popped unconditionally so it never stalls the stream.
    assign pop_grant = (grant_i && valid_o) || (pop_valid && !head_ok);

    always_comb begin
        data_d = data_q;
        if (grant_i && valid_o) begin
            data_d = head_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: tb/tb_fifo_top.sv
// Randomized bench for fifo_top against a queue-based reference of the FIFO rules.
module tb_fifo_top;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        grant_i = 1'b0;
    logic        grant_o;
    logic [32:0] data_o;
    logic        valid_o;

    fifo_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .grant_o (grant_o),
        .grant_i (grant_i),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] model_q[$];
    logic [32:0] exp_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word whose check bit (bit 0) is 0 = good, 1 = corrupt.
    function automatic logic [32:0] rand_word(input bit corrupt);
        logic [32:0] w;
        w = {$urandom, 1'b0};
        w[0] = corrupt;
        return w;
    endfunction

    // One clock: drive at negedge, check outputs, advance the model, let the posedge happen.
    task automatic cycle(input logic vi, input logic [32:0] di, input logic gi);
        int  size_before;
        bit  head_good;
        @(negedge clk);
        valid_i = vi;
        data_i  = di;
        grant_i = gi;
        #1;
        size_before = model_q.size();
        head_good   = (size_before > 0) && (model_q[0][0] == 1'b0);
        check_eq("grant_o", 64'(grant_o), 64'(size_before < DEPTH));
        check_eq("valid_o", 64'(valid_o), 64'(head_good));
        check_eq("data_o", 64'(data_o), 64'(exp_data));
        if (head_good && gi) exp_data = model_q.pop_front();
        else if (size_before > 0 && !head_good) void'(model_q.pop_front());
        if (vi && size_before < DEPTH) model_q.push_back(di);
        $display("cyc t=%0t vi=%0b di=%0h gi=%0b -> grant_o=%0b valid_o=%0b data_o=%0h occ=%0d",
                 $time, vi, di, gi, grant_o, valid_o, data_o, model_q.size());
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid_o"}, 64'(valid_o), 64'(0));
        check_eq({tag, "_grant_o"}, 64'(grant_o), 64'(1));
        check_eq({tag, "_data_o"}, 64'(data_o), 64'(0));
        check_eq({tag, "_ptr_read"}, 64'(dut.fifo_i.ptr_read_q), 64'(0));
        check_eq({tag, "_ptr_write"}, 64'(dut.fifo_i.ptr_write_q), 64'(0));
        check_eq({tag, "_flag"}, 64'(dut.fifo_i.flag_q), 64'(0));
    endtask

    initial begin
        logic [32:0] v;
        // Reset held 10 ns, released on a falling edge.
        #3;
        check_reset_state("reset");
        #7;
        rst_n = 1'b1;

        // Fill and overflow: six good words, only four fit.
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_word(1'b0), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("full_grant_o", 64'(grant_o), 64'(0));

        // Drain and underflow: six pops, two are ignored.
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Corrupt drop: 4, 5, 8 -> 5 is flushed.
        cycle(1'b1, 33'd4, 1'b0);
        cycle(1'b1, 33'd5, 1'b0);
        cycle(1'b1, 33'd8, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check_eq("corrupt_last", 64'(data_o), 64'(8));

        // Concurrent push and pop with alternating parity.
        v = 33'd1;
        for (int i = 0; i < 30; i++) begin
            v = v + 33'd3;
            cycle(1'b1, v, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        // Wrap stress: two pushes per pop, then one push per two pops.
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, rand_word($urandom_range(3) == 0), 1'b1);
            cycle(1'b1, rand_word($urandom_range(3) == 0), 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, rand_word($urandom_range(3) == 0), 1'b1);
            cycle(1'b0, '0, 1'b1);
        end

        // Free-running random traffic.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(1)), rand_word($urandom_range(3) == 0), 1'($urandom_range(1)));

        // Mid-operation asynchronous reset drops all stored words.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_word(1'b0), 1'b0);
        cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        grant_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        #2;
        rst_n = 1'b1;
        model_q.delete();
        exp_data = '0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 33'd6, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check_eq("post_reset_data", 64'(data_o), 64'(6));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
